// File: rtl/core_pkg.sv
// Shared decode constants and state types for the 4-bit core.
package core_pkg;

    typedef enum logic [1:0] {
        REG_A  = 2'd0,
        REG_B  = 2'd1,
        REG_MX = 2'd2,
        REG_MY = 2'd3
    } opsel_e;

    typedef enum logic [1:0] {
        FETCH,
        READ,
        EXEC,
        DONE
    } exec_state_e;

    localparam logic [11:0] OP_LD_RI  = 12'hE00;
    localparam logic [11:0] MSK_LD_RI = 12'hFC0;
    localparam logic [11:0] OP_LD_X   = 12'hB00;
    localparam logic [11:0] OP_LD_Y   = 12'h800;
    localparam logic [11:0] MSK_LD_XY = 12'hF00;
    localparam logic [11:0] OP_RLC    = 12'hAF0;
    localparam logic [11:0] MSK_RLC   = 12'hFF0;
    localparam logic [11:0] OP_RRC    = 12'hE8C;
    localparam logic [11:0] MSK_RRC   = 12'hFFC;
    localparam logic [11:0] OP_SCF    = 12'hF41;
    localparam logic [11:0] OP_RCF    = 12'hF5E;
    localparam logic [11:0] OP_NOP7   = 12'hFFF;

    // Index of the final cycle (instruction length minus one).
    localparam logic [2:0] LAST_SHORT = 3'd4;
    localparam logic [2:0] LAST_LONG  = 3'd6;

    function automatic logic op_match(
        input logic [11:0] ir,
        input logic [11:0] op,
        input logic [11:0] msk
    );
        return (ir & msk) == op;
    endfunction

endpackage

// File: rtl/core_rotate_alu.sv
// Rotate-through-carry unit; dir=0 rotates left (RLC), dir=1 right (RRC).
module core_rotate_alu (
    input  logic [3:0] value,
    input  logic       carry_in,
    input  logic       dir,
    output logic [3:0] result,
    output logic       carry_out,
    output logic       zero
);

    always_comb begin
        result    = {value[2:0], carry_in};
        carry_out = value[3];
        if (dir) begin
            result    = {carry_in, value[3:1]};
            carry_out = value[0];
        end
        zero = (result == 4'd0);
    end

endmodule

// File: rtl/core_bench_cpu.sv
// Minimal 4-bit E0C6200-style execution core with external ROM/RAM ports.
// Define CORE_DEBUG_EN to expose internal registers on the dbg_* outputs.
module core_bench_cpu
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    output logic [11:0] rom_addr,
    input  logic [11:0] rom_data,
    output logic [11:0] ram_addr,
    input  logic [3:0]  ram_rdata,
    output logic [3:0]  ram_wdata,
    output logic        ram_we,
    output logic        instr_done,
    output logic [3:0]  dbg_a,
    output logic [3:0]  dbg_b,
    output logic [11:0] dbg_x,
    output logic [11:0] dbg_y,
    output logic [7:0]  dbg_sp,
    output logic [11:0] dbg_pc,
    output logic        dbg_carry,
    output logic        dbg_zero
);

    exec_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [11:0] ir_q, ir_d;
    logic [3:0]  opnd_q, opnd_d;
    logic [11:0] pc_q, pc_d;
    logic [3:0]  a_q, a_d;
    logic [3:0]  b_q, b_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic [7:0]  sp_q, sp_d;
    logic        c_q, c_d;
    logic        z_q, z_d;

    logic   is_ldri, is_ldx, is_ldy, is_scf, is_rcf;
    logic   is_rlc, is_rrc, is_long, uses_sel, wr_mem;
    opsel_e sel;
    logic [2:0] last;
    logic [3:0] alu_res, wval, operand;
    logic       alu_c, alu_z;

    always_comb begin
        is_ldri  = op_match(ir_q, OP_LD_RI, MSK_LD_RI);
        is_ldx   = op_match(ir_q, OP_LD_X, MSK_LD_XY);
        is_ldy   = op_match(ir_q, OP_LD_Y, MSK_LD_XY);
        is_scf   = (ir_q == OP_SCF);
        is_rcf   = (ir_q == OP_RCF);
        is_rlc   = op_match(ir_q, OP_RLC, MSK_RLC)
                   && (ir_q[3:2] == ir_q[1:0]);
        is_rrc   = op_match(ir_q, OP_RRC, MSK_RRC);
        is_long  = is_scf | is_rcf | is_rlc
                   | (ir_q == OP_NOP7);
        last     = is_long ? LAST_LONG : LAST_SHORT;
        sel      = opsel_e'(is_ldri ? ir_q[5:4] : ir_q[1:0]);
        uses_sel = is_ldri | is_rlc | is_rrc;
        wr_mem   = uses_sel
                   && (sel == REG_MX || sel == REG_MY);
    end

    assign ram_addr = (sel == REG_MY) ? y_q : x_q;
    assign rom_addr = pc_q;

    always_comb begin
        unique case (sel)
            REG_A:   operand = a_q;
            REG_B:   operand = b_q;
            default: operand = ram_rdata;
        endcase
    end

    core_rotate_alu u_alu (
        .value     (opnd_q),
        .carry_in  (c_q),
        .dir       (is_rrc),
        .result    (alu_res),
        .carry_out (alu_c),
        .zero      (alu_z)
    );

    assign wval      = is_ldri ? ir_q[3:0] : alu_res;
    assign ram_wdata = wval;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ir_d       = ir_q;
        opnd_d     = opnd_q;
        pc_d       = pc_q;
        a_d        = a_q;
        b_d        = b_q;
        x_d        = x_q;
        y_d        = y_q;
        sp_d       = sp_q;
        c_d        = c_q;
        z_d        = z_q;
        instr_done = 1'b0;
        ram_we     = 1'b0;
        unique case (state_q)
            FETCH: begin
                ir_d    = rom_data;
                cnt_d   = 3'd1;
                state_d = READ;
            end
            READ: begin
                opnd_d  = operand;
                cnt_d   = cnt_q + 3'd1;
                state_d = EXEC;
            end
            EXEC: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == last - 3'd1) state_d = DONE;
            end
            DONE: begin
                instr_done = 1'b1;
                ram_we     = wr_mem;
                pc_d       = pc_q + 12'd1;
                cnt_d      = 3'd0;
                state_d    = FETCH;
                unique case (1'b1)
                    is_ldx: x_d[7:0] = ir_q[7:0];
                    is_ldy: y_d[7:0] = ir_q[7:0];
                    is_scf: c_d = 1'b1;
                    is_rcf: c_d = 1'b0;
                    is_rlc, is_rrc: begin
                        c_d = alu_c;
                        z_d = alu_z;
                    end
                    default: ;
                endcase
                if (uses_sel) begin
                    unique case (sel)
                        REG_A:   a_d = wval;
                        REG_B:   b_d = wval;
                        default: ;
                    endcase
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
            cnt_q   <= '0;
            ir_q    <= '0;
            opnd_q  <= '0;
            pc_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sp_q    <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ir_q    <= ir_d;
            opnd_q  <= opnd_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sp_q    <= sp_d;
            c_q     <= c_d;
            z_q     <= z_d;
        end
    end

`ifdef CORE_DEBUG_EN
    assign dbg_a     = a_q;
    assign dbg_b     = b_q;
    assign dbg_x     = x_q;
    assign dbg_y     = y_q;
    assign dbg_sp    = sp_q;
    assign dbg_pc    = pc_q;
    assign dbg_carry = c_q;
    assign dbg_zero  = z_q;
`else
    logic unused_dbg;
    assign unused_dbg = ^{sp_q, z_q};
    assign dbg_a      = '0;
    assign dbg_b      = '0;
    assign dbg_x      = '0;
    assign dbg_y      = '0;
    assign dbg_sp     = '0;
    assign dbg_pc     = '0;
    assign dbg_carry  = 1'b0;
    assign dbg_zero   = 1'b0;
`endif

endmodule

// File: tb/tb_core_bench_cpu.sv
// Directed bench for core_bench_cpu: rotates on A/B/M(X)/M(Y) and reset abort.
module tb_core_bench_cpu;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] rom_addr, rom_data, ram_addr;
    logic [3:0]  ram_rdata, ram_wdata;
    logic        ram_we, instr_done;
    logic [3:0]  dbg_a, dbg_b;
    logic [11:0] dbg_x, dbg_y, dbg_pc;
    logic [7:0]  dbg_sp;
    logic        dbg_carry, dbg_zero;

    logic [11:0] rom [0:4095];
    logic [3:0]  ram [0:4095];
    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [3:0]  pre_data = '0;

    int ncmp = 0;
    int nbad = 0;

    localparam logic [11:0] XA = 12'h010;
    localparam logic [11:0] YA = 12'h020;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (ram_we) ram[ram_addr] <= ram_wdata;
    end

    assign rom_data  = rom[rom_addr];
    assign ram_rdata = ram[ram_addr];

    core_bench_cpu dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .ram_addr   (ram_addr),
        .ram_rdata  (ram_rdata),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .instr_done (instr_done),
        .dbg_a      (dbg_a),
        .dbg_b      (dbg_b),
        .dbg_x      (dbg_x),
        .dbg_y      (dbg_y),
        .dbg_sp     (dbg_sp),
        .dbg_pc     (dbg_pc),
        .dbg_carry  (dbg_carry),
        .dbg_zero   (dbg_zero)
    );

    task automatic chk(input string tag,
                       input logic [11:0] obs,
                       input logic [11:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag,
                            input logic [3:0] ea, input logic [3:0] eb,
                            input logic [11:0] ex, input logic [11:0] ey,
                            input logic [11:0] epc,
                            input logic ec, input logic ez);
`ifdef CORE_DEBUG_EN
        chk({tag, ".a"}, {8'd0, dbg_a}, {8'd0, ea});
        chk({tag, ".b"}, {8'd0, dbg_b}, {8'd0, eb});
        chk({tag, ".x"}, dbg_x, ex);
        chk({tag, ".y"}, dbg_y, ey);
        chk({tag, ".sp"}, {4'd0, dbg_sp}, 12'd0);
        chk({tag, ".pc"}, dbg_pc, epc);
        chk({tag, ".c"}, {11'd0, dbg_carry}, {11'd0, ec});
        chk({tag, ".z"}, {11'd0, dbg_zero}, {11'd0, ez});
`else
        chk({tag, ".dbg0"},
            {dbg_a, dbg_b, dbg_sp} | dbg_x | dbg_y | dbg_pc
            | {10'd0, dbg_carry, dbg_zero}, 12'd0);
`endif
        chk({tag, ".rom_addr"}, rom_addr, epc);
    endtask

    // Reset, preload RAM, load program and run up to the fetch of PC=5.
    task automatic start_case(input string tag,
                              input logic [11:0] ins,
                              input logic cset);
        @(negedge clk);
        reset_n  = 1'b0;
        rom[0] = 12'hB10;
        rom[1] = 12'h820;
        rom[2] = 12'hE01;
        rom[3] = 12'hE18;
        rom[4] = cset ? 12'hF41 : 12'hF5E;
        rom[5] = ins;
        rom[6] = 12'hFFF;
        pre_we   = 1'b1;
        pre_addr = XA;
        pre_data = 4'd7;
        @(negedge clk);
        pre_addr = YA;
        pre_data = 4'd4;
        @(negedge clk);
        pre_we  = 1'b0;
        reset_n = 1'b1;
        for (int k = 0; k < 80; k++) begin
            if (rom_addr == 12'd5) break;
            @(negedge clk);
        end
        chk({tag, ".reach_pc5"}, rom_addr, 12'd5);
    endtask

    task automatic run_case(input string tag, input logic [11:0] ins,
                            input logic cset,
                            input logic [3:0] ea, input logic [3:0] eb,
                            input logic [3:0] emx, input logic [3:0] emy,
                            input logic ec, input logic ez,
                            input int elen, input logic emem);
        int len;
        logic we_done;
        len = 0;
        we_done = 1'b0;
        start_case(tag, ins, cset);
        for (int k = 1; k <= 12; k++) begin
            if (instr_done) begin
                len = k;
                we_done = ram_we;
                break;
            end
            @(negedge clk);
        end
        chk({tag, ".len"}, 12'(len), 12'(elen));
        chk({tag, ".we"}, {11'd0, we_done}, {11'd0, emem});
        @(negedge clk);
        chk_regs(tag, ea, eb, XA, YA, 12'd6, ec, ez);
        chk({tag, ".mx"}, {8'd0, ram[XA]}, {8'd0, emx});
        chk({tag, ".my"}, {8'd0, ram[YA]}, {8'd0, emy});
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 12'hFFF;

        @(negedge clk);
        chk_regs("reset", 4'd0, 4'd0, 12'd0, 12'd0, 12'd0, 1'b0, 1'b0);
        chk("reset.done", {11'd0, instr_done}, 12'd0);
        chk("reset.we", {11'd0, ram_we}, 12'd0);

        run_case("rlc_a", 12'hAF0, 1'b0,
                 4'd2, 4'd8, 4'd7, 4'd4, 1'b0, 1'b0, 7, 1'b0);
        run_case("rlc_b", 12'hAF5, 1'b1,
                 4'd1, 4'd1, 4'd7, 4'd4, 1'b1, 1'b0, 7, 1'b0);
        run_case("rrc_a", 12'hE8C, 1'b0,
                 4'd0, 4'd8, 4'd7, 4'd4, 1'b1, 1'b1, 5, 1'b0);
        run_case("rrc_mx", 12'hE8E, 1'b1,
                 4'd1, 4'd8, 4'hB, 4'd4, 1'b1, 1'b0, 5, 1'b1);
        run_case("rlc_my", 12'hAFF, 1'b0,
                 4'd1, 4'd8, 4'd7, 4'd8, 1'b0, 1'b0, 7, 1'b1);

        start_case("rst_mid", 12'hAFA, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_regs("rst_mid", 4'd0, 4'd0, 12'd0, 12'd0, 12'd0, 1'b0, 1'b0);
        chk("rst_mid.we", {11'd0, ram_we}, 12'd0);
        chk("rst_mid.done", {11'd0, instr_done}, 12'd0);
        repeat (3) @(negedge clk);
        chk("rst_mid.mx", {8'd0, ram[XA]}, 12'd7);
        chk("rst_mid.my", {8'd0, ram[YA]}, 12'd4);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_mid.refetch_pc", rom_addr, 12'd0);
        chk("rst_mid.refetch_done", {11'd0, instr_done}, 12'd0);
        chk("rst_mid.mx_after", {8'd0, ram[XA]}, 12'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nbad);
        $finish;
    end

endmodule
